// File: rtl/mem_pkg.sv
// Shared types and constants for the matrix-pipeline memory stage.
package mem_pkg;

    typedef enum logic [2:0] {
        MOP_ALU = 3'd0,
        MOP_LW  = 3'd1,
        MOP_SW  = 3'd2,
        MOP_MLD = 3'd3,
        MOP_MST = 3'd4
    } mem_op_e;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SREQ  = 3'd1,
        SWAIT = 3'd2,
        MREQ  = 3'd3,
        MWAIT = 3'd4
    } mem_state_e;

    localparam logic [1:0] WB_SEL_MEM = 2'b11;
    localparam int         ROW_WORDS  = 4;

endpackage

// File: rtl/mem_wb_reg.sv
// Registered MEM/WB beat: fields are loaded only with a valid beat and read 0 otherwise.
module mem_wb_reg (
    input  logic        clk,
    input  logic        rstn,
    input  logic        ld_valid,
    input  logic [31:0] ld_mem_data,
    input  logic [31:0] ld_alu_o,
    input  logic [1:0]  ld_matrix2reg,
    input  logic        ld_reg2matrix,
    input  logic [1:0]  ld_matrix_index,
    output logic        wb_valid,
    output logic [31:0] wb_mem_data,
    output logic [31:0] wb_alu_o,
    output logic [1:0]  wb_mem_matrix2reg,
    output logic        wb_mem_reg2matrix,
    output logic [1:0]  wb_matrix_index
);

    always_ff @(posedge clk) begin
        if (!rstn || !ld_valid) begin
            wb_valid          <= 1'b0;
            wb_mem_data       <= '0;
            wb_alu_o          <= '0;
            wb_mem_matrix2reg <= '0;
            wb_mem_reg2matrix <= 1'b0;
            wb_matrix_index   <= '0;
        end else begin
            wb_valid          <= 1'b1;
            wb_mem_data       <= ld_mem_data;
            wb_alu_o          <= ld_alu_o;
            wb_mem_matrix2reg <= ld_matrix2reg;
            wb_mem_reg2matrix <= ld_reg2matrix;
            wb_matrix_index   <= ld_matrix_index;
        end
    end

endmodule

// File: rtl/stage_mem_mline.sv
// Memory stage: scalar LW/SW and 4-word matrix-row MLD/MST over a single-outstanding
// handshaked dmem port, with MLD rows streamed to write-back one column per beat.
module stage_mem_mline
    import mem_pkg::*;
#(
    parameter int ROW_WORDS = 4
) (
    input  logic                        clk,
    input  logic                        rstn,
    input  logic                        me_valid,
    input  logic [2:0]                  me_op,
    input  logic [31:0]                 me_alu_o,
    input  logic [31:0]                 me_regs_data2,
    input  logic [ROW_WORDS-1:0][31:0]  me_matrix_row,
    output logic                        dmem_req,
    output logic                        dmem_we,
    output logic [31:0]                 dmem_addr,
    output logic [31:0]                 dmem_wdata,
    input  logic                        dmem_gnt,
    input  logic                        dmem_rvalid,
    input  logic [31:0]                 dmem_rdata,
    output logic                        wb_valid,
    output logic [31:0]                 wb_mem_data,
    output logic [31:0]                 wb_alu_o,
    output logic [1:0]                  wb_mem_matrix2reg,
    output logic                        wb_mem_reg2matrix,
    output logic [1:0]                  wb_matrix_index,
    output logic                        mem_stall
);

    mem_state_e                 state, state_nxt;
    mem_op_e                    op_q;
    logic [31:0]                addr_q;
    logic [31:0]                alu_q;
    logic [31:0]                sdata_q;
    logic [ROW_WORDS-1:0][31:0] row_q;
    logic [1:0]                 cnt;

    logic        cap;
    logic        is_store;
    logic        last_beat;
    logic        ld_valid;
    logic [31:0] ld_mem_data;
    logic [31:0] ld_alu_o;
    logic [1:0]  ld_matrix2reg;
    logic        ld_reg2matrix;
    logic [1:0]  ld_matrix_index;

    assign cap       = (state == IDLE) && me_valid;
    assign is_store  = (op_q == MOP_SW) || (op_q == MOP_MST);
    assign last_beat = (cnt == 2'(ROW_WORDS - 1));

    always_ff @(posedge clk) begin
        if (!rstn) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (me_valid) begin
                    case (mem_op_e'(me_op))
                        MOP_LW, MOP_SW:   state_nxt = SREQ;
                        MOP_MLD, MOP_MST: state_nxt = MREQ;
                        default:          state_nxt = IDLE;
                    endcase
                end
            end
            SREQ:  if (dmem_gnt) state_nxt = (op_q == MOP_SW) ? IDLE : SWAIT;
            SWAIT: if (dmem_rvalid) state_nxt = IDLE;
            MREQ: begin
                if (dmem_gnt) begin
                    if (op_q == MOP_MST) state_nxt = last_beat ? IDLE : MREQ;
                    else                 state_nxt = MWAIT;
                end
            end
            MWAIT: if (dmem_rvalid) state_nxt = last_beat ? IDLE : MREQ;
            default: state_nxt = IDLE;
        endcase
    end

    // Operands are frozen at capture so the dmem fields stay stable while a grant is pending.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            op_q    <= MOP_ALU;
            addr_q  <= '0;
            alu_q   <= '0;
            sdata_q <= '0;
            row_q   <= '0;
            cnt     <= '0;
        end else if (cap) begin
            op_q    <= mem_op_e'(me_op);
            addr_q  <= {me_alu_o[31:2], 2'b00};
            alu_q   <= me_alu_o;
            sdata_q <= me_regs_data2;
            row_q   <= me_matrix_row;
            cnt     <= '0;
        end else if ((state == MREQ && dmem_gnt && op_q == MOP_MST) ||
                     (state == MWAIT && dmem_rvalid && !last_beat)) begin
            cnt <= cnt + 2'd1;
        end
    end

    always_comb begin
        dmem_req        = 1'b0;
        dmem_we         = 1'b0;
        dmem_addr       = '0;
        dmem_wdata      = '0;
        ld_valid        = 1'b0;
        ld_mem_data     = '0;
        ld_alu_o        = '0;
        ld_matrix2reg   = '0;
        ld_reg2matrix   = 1'b0;
        ld_matrix_index = '0;
        case (state)
            IDLE: begin
                if (me_valid && mem_op_e'(me_op) == MOP_ALU) begin
                    ld_valid = 1'b1;
                    ld_alu_o = me_alu_o;
                end
            end
            SREQ: begin
                dmem_req   = 1'b1;
                dmem_we    = is_store;
                dmem_addr  = addr_q;
                dmem_wdata = is_store ? sdata_q : 32'd0;
            end
            SWAIT: begin
                if (dmem_rvalid) begin
                    ld_valid      = 1'b1;
                    ld_mem_data   = dmem_rdata;
                    ld_alu_o      = alu_q;
                    ld_matrix2reg = WB_SEL_MEM;
                end
            end
            MREQ: begin
                dmem_req   = 1'b1;
                dmem_we    = is_store;
                dmem_addr  = addr_q + {28'd0, cnt, 2'b00};
                dmem_wdata = is_store ? row_q[cnt] : 32'd0;
            end
            MWAIT: begin
                if (dmem_rvalid) begin
                    ld_valid        = 1'b1;
                    ld_mem_data     = dmem_rdata;
                    ld_alu_o        = alu_q;
                    ld_reg2matrix   = 1'b1;
                    ld_matrix_index = cnt;
                end
            end
            default: ;
        endcase
    end

    assign mem_stall = (state != IDLE);

    mem_wb_reg u_wb (
        .clk              (clk),
        .rstn             (rstn),
        .ld_valid         (ld_valid),
        .ld_mem_data      (ld_mem_data),
        .ld_alu_o         (ld_alu_o),
        .ld_matrix2reg    (ld_matrix2reg),
        .ld_reg2matrix    (ld_reg2matrix),
        .ld_matrix_index  (ld_matrix_index),
        .wb_valid         (wb_valid),
        .wb_mem_data      (wb_mem_data),
        .wb_alu_o         (wb_alu_o),
        .wb_mem_matrix2reg(wb_mem_matrix2reg),
        .wb_mem_reg2matrix(wb_mem_reg2matrix),
        .wb_matrix_index  (wb_matrix_index)
    );

endmodule

// File: tb/tb_stage_mem_mline.sv
// Directed bench for stage_mem_mline: ALU, LW, MLD wrap, MST with grant stall, reset mid-burst.
module tb_stage_mem_mline;
    import mem_pkg::*;

    logic              clk = 1'b0;
    logic              rstn;
    logic              me_valid;
    logic [2:0]        me_op;
    logic [31:0]       me_alu_o;
    logic [31:0]       me_regs_data2;
    logic [3:0][31:0]  me_matrix_row;
    logic              dmem_req, dmem_we;
    logic [31:0]       dmem_addr, dmem_wdata;
    logic              dmem_gnt, dmem_rvalid;
    logic [31:0]       dmem_rdata;
    logic              wb_valid;
    logic [31:0]       wb_mem_data, wb_alu_o;
    logic [1:0]        wb_mem_matrix2reg;
    logic              wb_mem_reg2matrix;
    logic [1:0]        wb_matrix_index;
    logic              mem_stall;

    int vec  = 0;
    int miss = 0;

    always #5 clk = ~clk;

    stage_mem_mline #(.ROW_WORDS(4)) dut (
        .clk(clk), .rstn(rstn),
        .me_valid(me_valid), .me_op(me_op), .me_alu_o(me_alu_o),
        .me_regs_data2(me_regs_data2), .me_matrix_row(me_matrix_row),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid),
        .dmem_rdata(dmem_rdata),
        .wb_valid(wb_valid), .wb_mem_data(wb_mem_data), .wb_alu_o(wb_alu_o),
        .wb_mem_matrix2reg(wb_mem_matrix2reg), .wb_mem_reg2matrix(wb_mem_reg2matrix),
        .wb_matrix_index(wb_matrix_index), .mem_stall(mem_stall)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec++;
        assert (obs === exp) else begin
            miss++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, ".req"},   {31'd0, dmem_req},  32'd0);
        chk({tag, ".we"},    {31'd0, dmem_we},   32'd0);
        chk({tag, ".addr"},  dmem_addr,          32'd0);
        chk({tag, ".wdata"}, dmem_wdata,         32'd0);
        chk({tag, ".wbv"},   {31'd0, wb_valid},  32'd0);
        chk({tag, ".wbd"},   wb_mem_data,        32'd0);
        chk({tag, ".wba"},   wb_alu_o,           32'd0);
        chk({tag, ".m2r"},   {30'd0, wb_mem_matrix2reg}, 32'd0);
        chk({tag, ".r2m"},   {31'd0, wb_mem_reg2matrix}, 32'd0);
        chk({tag, ".idx"},   {30'd0, wb_matrix_index},   32'd0);
        chk({tag, ".stall"}, {31'd0, mem_stall}, 32'd0);
    endtask

    // Issues an LW from IDLE with same-cycle grant and next-cycle rvalid.
    task automatic do_lw(input string tag, input logic [31:0] a, input logic [31:0] exp_a,
                         input logic [31:0] d);
        me_valid = 1'b1; me_op = MOP_LW; me_alu_o = a;
        tick();
        me_valid = 1'b0;
        chk({tag, ".req"},   {31'd0, dmem_req},  32'd1);
        chk({tag, ".we"},    {31'd0, dmem_we},   32'd0);
        chk({tag, ".addr"},  dmem_addr,          exp_a);
        chk({tag, ".stall1"}, {31'd0, mem_stall}, 32'd1);
        dmem_gnt = 1'b1;
        tick();
        dmem_gnt = 1'b0;
        chk({tag, ".req_off"}, {31'd0, dmem_req}, 32'd0);
        chk({tag, ".stall2"}, {31'd0, mem_stall}, 32'd1);
        dmem_rvalid = 1'b1; dmem_rdata = d;
        tick();
        dmem_rvalid = 1'b0; dmem_rdata = '0;
        chk({tag, ".wbv"},   {31'd0, wb_valid},  32'd1);
        chk({tag, ".wbd"},   wb_mem_data,        d);
        chk({tag, ".m2r"},   {30'd0, wb_mem_matrix2reg}, 32'd3);
        chk({tag, ".r2m"},   {31'd0, wb_mem_reg2matrix}, 32'd0);
        chk({tag, ".stall3"}, {31'd0, mem_stall}, 32'd0);
        tick();
        chk({tag, ".wbv_end"}, {31'd0, wb_valid}, 32'd0);
    endtask

    initial begin
        logic [31:0] mld_addr [4];
        logic [31:0] mst_data [4];
        mld_addr = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};
        mst_data = '{32'hA0A0_0000, 32'hA1A1_1111, 32'hA2A2_2222, 32'hA3A3_3333};

        rstn = 1'b0; me_valid = 1'b0; me_op = MOP_ALU; me_alu_o = '0;
        me_regs_data2 = '0; me_matrix_row = '0;
        dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = '0;
        tick(); tick();
        chk_idle_outputs("reset");
        rstn = 1'b1;

        // three back-to-back ALU ops, never stalling
        me_valid = 1'b1; me_op = MOP_ALU; me_alu_o = 32'h1234;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("alu%0d.wbv", i), {31'd0, wb_valid}, 32'd1);
            chk($sformatf("alu%0d.wba", i), wb_alu_o, 32'h1234);
            chk($sformatf("alu%0d.m2r", i), {30'd0, wb_mem_matrix2reg}, 32'd0);
            chk($sformatf("alu%0d.stall", i), {31'd0, mem_stall}, 32'd0);
            chk($sformatf("alu%0d.req", i), {31'd0, dmem_req}, 32'd0);
        end
        me_valid = 1'b0; me_alu_o = '0;
        tick();
        chk("alu.wbv_end", {31'd0, wb_valid}, 32'd0);
        chk("alu.wba_zero", wb_alu_o, 32'd0);

        do_lw("lw", 32'h0000_0103, 32'h0000_0100, 32'hDEAD_BEEF);

        // MLD across the top of the address space
        me_valid = 1'b1; me_op = MOP_MLD; me_alu_o = 32'hFFFF_FFF8;
        tick();
        me_valid = 1'b0; me_alu_o = '0;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("mld%0d.req", i), {31'd0, dmem_req}, 32'd1);
            chk($sformatf("mld%0d.we", i), {31'd0, dmem_we}, 32'd0);
            chk($sformatf("mld%0d.addr", i), dmem_addr, mld_addr[i]);
            chk($sformatf("mld%0d.stall", i), {31'd0, mem_stall}, 32'd1);
            dmem_gnt = 1'b1;
            tick();
            dmem_gnt = 1'b0;
            chk($sformatf("mld%0d.wait_req", i), {31'd0, dmem_req}, 32'd0);
            chk($sformatf("mld%0d.wait_wbv", i), {31'd0, wb_valid}, 32'd0);
            dmem_rvalid = 1'b1; dmem_rdata = 32'(i + 1);
            tick();
            dmem_rvalid = 1'b0; dmem_rdata = '0;
            chk($sformatf("mld%0d.wbv", i), {31'd0, wb_valid}, 32'd1);
            chk($sformatf("mld%0d.wbd", i), wb_mem_data, 32'(i + 1));
            chk($sformatf("mld%0d.idx", i), {30'd0, wb_matrix_index}, 32'(i));
            chk($sformatf("mld%0d.r2m", i), {31'd0, wb_mem_reg2matrix}, 32'd1);
            chk($sformatf("mld%0d.m2r", i), {30'd0, wb_mem_matrix2reg}, 32'd0);
        end
        chk("mld.stall_end", {31'd0, mem_stall}, 32'd0);
        tick();
        chk("mld.wbv_end", {31'd0, wb_valid}, 32'd0);

        // MST; row inputs are scrubbed after capture, grant withheld 3 cycles on beat 1
        me_valid = 1'b1; me_op = MOP_MST; me_alu_o = 32'h0000_0202;
        for (int i = 0; i < 4; i++) me_matrix_row[i] = mst_data[i];
        tick();
        me_valid = 1'b0; me_alu_o = '0; me_matrix_row = '0;
        for (int i = 0; i < 4; i++) begin
            if (i == 1) begin
                for (int w = 0; w < 3; w++) begin
                    chk($sformatf("mst.hold%0d.req", w), {31'd0, dmem_req}, 32'd1);
                    chk($sformatf("mst.hold%0d.addr", w), dmem_addr, 32'h0000_0204);
                    chk($sformatf("mst.hold%0d.wdata", w), dmem_wdata, mst_data[1]);
                    tick();
                end
            end
            chk($sformatf("mst%0d.req", i), {31'd0, dmem_req}, 32'd1);
            chk($sformatf("mst%0d.we", i), {31'd0, dmem_we}, 32'd1);
            chk($sformatf("mst%0d.addr", i), dmem_addr, 32'h0000_0200 + 32'(4 * i));
            chk($sformatf("mst%0d.wdata", i), dmem_wdata, mst_data[i]);
            chk($sformatf("mst%0d.wbv", i), {31'd0, wb_valid}, 32'd0);
            dmem_gnt = 1'b1;
            tick();
            dmem_gnt = 1'b0;
        end
        chk("mst.req_end", {31'd0, dmem_req}, 32'd0);
        chk("mst.stall_end", {31'd0, mem_stall}, 32'd0);
        chk("mst.wbv_end", {31'd0, wb_valid}, 32'd0);

        // reset while waiting for MLD beat 1 data, then a stray rvalid
        me_valid = 1'b1; me_op = MOP_MLD; me_alu_o = 32'h0000_0300;
        tick();
        me_valid = 1'b0; me_alu_o = '0;
        dmem_gnt = 1'b1; tick(); dmem_gnt = 1'b0;
        dmem_rvalid = 1'b1; dmem_rdata = 32'h55; tick(); dmem_rvalid = 1'b0;
        chk("rst.beat0", {31'd0, wb_valid}, 32'd1);
        chk("rst.addr1", dmem_addr, 32'h0000_0304);
        dmem_gnt = 1'b1; tick(); dmem_gnt = 1'b0;
        chk("rst.in_mwait", {31'd0, mem_stall}, 32'd1);
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        chk_idle_outputs("rst.mid");
        dmem_rvalid = 1'b1; dmem_rdata = 32'h66;
        tick();
        dmem_rvalid = 1'b0; dmem_rdata = '0;
        chk_idle_outputs("rst.stray");

        do_lw("lw2", 32'h0000_0042, 32'h0000_0040, 32'hCAFE_F00D);

        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
